// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state encoding, button count and priority select for the button capture front end
package btn_pkg;
    localparam int NUM_BTN = 4;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
    function automatic logic [NUM_BTN-1:0] prio_sel(input logic [NUM_BTN-1:0] v);
        return v[3] ? 4'b1000 : v[2] ? 4'b0100 : v[1] ? 4'b0010 : v[0] ? 4'b0001 : 4'b0000;
    endfunction
endpackage

// File: rtl/btn_debounce_cell.sv
// btn_debounce_cell: synchroniser, debounce counter and stable level for one button, with a press pulse
module btn_debounce_cell #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16,
    parameter int DEB_CNT     = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_stable,
    output logic o_press
);
    logic [SYNC_STAGES-1:0] r_sync, r_warm;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_stable, r_press, r_armed;
    logic                   w_sync, w_diff, w_accept;
    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_sync != r_stable;
    assign w_accept = w_diff && (r_cnt == DEB_W'(DEB_CNT - 1));
    assign o_stable = r_stable;
    assign o_press  = r_press;
    // A button only becomes armed once it has been seen released after the synchroniser has
    // filled, so a button held through reset never reports a press.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_sync   <= '0;
            r_warm   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_warm  <= {r_warm[SYNC_STAGES-2:0], 1'b1};
            r_cnt   <= (w_diff && !w_accept) ? r_cnt + 1'b1 : '0;
            r_press <= w_accept && w_sync && r_armed;
            if (w_accept) r_stable <= w_sync;
            if (r_warm[SYNC_STAGES-1] && !w_sync) r_armed <= 1'b1;
        end
endmodule

// File: rtl/btn_onehot_capture.sv
// btn_onehot_capture: debounced button presses captured as a held one-hot {d,c,b,a} with valid/ack handshake.
// Define STICKY_PENDING_EN to queue ungranted presses in a pending register instead of dropping them.
module btn_onehot_capture
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 16,
    parameter int DEB_CNT     = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       ack,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       valid,
    output logic       overrun
);
    state_t             r_state, w_state_n;
    logic [NUM_BTN-1:0] r_hot, w_hot_n, w_press, w_stable, w_grant;
    logic               r_ovr, w_lost;
    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_cell
            btn_debounce_cell #(
                .SYNC_STAGES(SYNC_STAGES),
                .DEB_W      (DEB_W),
                .DEB_CNT    (DEB_CNT)
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .i_btn   (btn[i]),
                .o_stable(w_stable[i]),
                .o_press (w_press[i])
            );
        end
    endgenerate
`ifdef STICKY_PENDING_EN
    logic [NUM_BTN-1:0] r_pend, w_cand;
    assign w_cand  = r_pend | w_press;
    assign w_grant = (r_state == IDLE) ? prio_sel(w_cand) : '0;
    assign w_lost  = |(w_press & r_pend);
    always_ff @(posedge clk or posedge rst)
        if (rst) r_pend <= '0;
        else     r_pend <= w_cand & ~w_grant;
`else
    assign w_grant = (r_state == IDLE) ? prio_sel(w_press) : '0;
    assign w_lost  = |(w_press & ~w_grant);
`endif
    always_comb begin
        w_state_n = r_state;
        w_hot_n   = r_hot;
        if (r_state == IDLE) begin
            w_state_n = |w_grant ? HOLD : IDLE;
            w_hot_n   = w_grant;
        end else if (ack) begin
            w_state_n = IDLE;
            w_hot_n   = '0;
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_hot   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_hot   <= w_hot_n;
            r_ovr   <= r_ovr | w_lost;
        end
    assign {d, c, b, a} = r_hot;
    assign valid        = (r_state == HOLD);
    assign overrun      = r_ovr;
`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (rst)
        (valid == |{d, c, b, a}) && $onehot0({d, c, b, a}));
    a_press_stable: assert property (@(posedge clk) disable iff (rst)
        (w_press & ~w_stable) == '0);
`endif
endmodule
